// File: rtl/ntt_ctrl_if.sv
// Control/handshake bundle between the NTT sequencer and its RAM/butterfly datapath.
// master drives the start request; slave (the sequencer) drives everything else.
interface ntt_ctrl_if;
  logic       i_start;
  logic       i_intt;
  logic       o_busy;
  logic       o_done;
  logic       o_rd_en;
  logic [7:0] o_rd_addr_a;
  logic [7:0] o_rd_addr_b;
  logic [6:0] o_zeta_idx;
  logic       o_bfu_intt;
  logic       o_wr_en;
  logic [7:0] o_wr_addr_a;
  logic [7:0] o_wr_addr_b;

  modport master (
    output i_start, i_intt,
    input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_zeta_idx,
    input  o_bfu_intt, o_wr_en, o_wr_addr_a, o_wr_addr_b
  );

  modport slave (
    input  i_start, i_intt,
    output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_zeta_idx,
    output o_bfu_intt, o_wr_en, o_wr_addr_a, o_wr_addr_b
  );
endinterface

// File: rtl/ntt_ctrl.sv
// 256-point NTT/INTT sequencer: 7 layers x 128 butterflies, writes trail reads by RD_LAT+BFU_LAT.
// No backpressure; each layer drains its write pipe before the next layer reads.
module ntt_ctrl #(
  parameter int RD_LAT  = 1,
  parameter int BFU_LAT = 4
) (
  input logic        i_clk,
  input logic        i_rst,
  ntt_ctrl_if.slave  bus
);
  localparam int P = RD_LAT + BFU_LAT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t     state;
  logic [2:0] layer;
  logic [6:0] cnt;
  logic       intt_q;
  logic       busy_q;
  logic       done_q;
  logic       rd_en;
  logic [7:0] rd_a;
  logic [7:0] rd_b;
  logic [6:0] zeta;

  logic [P:1] pv;
  logic [7:0] pa [1:P];
  logic [7:0] pb [1:P];

  // sh = log2(len); forward shrinks len per layer, inverse grows it
  logic [2:0] sh;
  logic [6:0] lenm;
  logic [6:0] blk;
  logic [6:0] cmod;
  logic [7:0] j;
  logic [7:0] len;
  logic [6:0] zf;
  logic [6:0] zi;
  logic       pipe_busy;

  always_comb begin
    sh   = intt_q ? (layer + 3'd1) : (3'd7 - layer);
    lenm = 7'h7f >> (3'd7 - sh);
    len  = {1'b0, lenm} + 8'd1;
    blk  = cnt >> sh;
    cmod = cnt & lenm;
    j    = ({1'b0, blk} << ({1'b0, sh} + 4'd1)) | {1'b0, cmod};
    zf   = (7'd1 << (3'd7 - sh)) + blk;
    zi   = (7'h7f >> (sh - 3'd1)) - blk;
  end

  // Only the entry about to reach the write stage may remain when the next layer starts reading
  always_comb begin
    pipe_busy = rd_en;
    for (int k = 1; k <= P - 2; k++) pipe_busy = pipe_busy | pv[k];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      layer  <= 3'd0;
      cnt    <= 7'd0;
      intt_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_en  <= 1'b0;
      rd_a   <= 8'd0;
      rd_b   <= 8'd0;
      zeta   <= 7'd0;
    end else begin
      done_q <= 1'b0;
      rd_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state  <= ISSUE;
            busy_q <= 1'b1;
            intt_q <= bus.i_intt;
            layer  <= 3'd0;
            cnt    <= 7'd0;
          end
        end
        ISSUE: begin
          rd_en <= 1'b1;
          rd_a  <= j;
          rd_b  <= j + len;
          zeta  <= intt_q ? zi : zf;
          cnt   <= cnt + 7'd1;
          if (cnt == 7'd127) state <= DRAIN;
        end
        DRAIN: begin
          if (!pipe_busy) begin
            if (layer == 3'd6) begin
              state <= FIN;
            end else begin
              layer <= layer + 3'd1;
              state <= ISSUE;
            end
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pv <= '0;
      for (int k = 1; k <= P; k++) begin
        pa[k] <= 8'd0;
        pb[k] <= 8'd0;
      end
    end else begin
      pv[1] <= rd_en;
      pa[1] <= rd_a;
      pb[1] <= rd_b;
      for (int k = 2; k <= P; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
        pb[k] <= pb[k-1];
      end
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_rd_en     = rd_en;
  assign bus.o_rd_addr_a = rd_a;
  assign bus.o_rd_addr_b = rd_b;
  assign bus.o_zeta_idx  = zeta;
  assign bus.o_bfu_intt  = intt_q;
  assign bus.o_wr_en     = pv[P];
  assign bus.o_wr_addr_a = pa[P];
  assign bus.o_wr_addr_b = pb[P];
endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: random start/mode/spurious-start stimulus against a cycle-offset reference model.
module tb_ntt_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_ctrl_if bus ();
  ntt_ctrl #(.RD_LAT(1), .BFU_LAT(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input int got, input int want);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, got, want, $time);
    end
  endtask

  // Butterfly pair for layer L, issue c, straight from the index rules
  function automatic void pair(input int L, input int c, input int m,
                               output int a, output int b, output int z);
    int len;
    int blk;
    len = m ? (2 << L) : (128 >> L);
    blk = c / len;
    a   = 2 * len * blk + (c % len);
    b   = a + len;
    z   = m ? (256 / len - 1 - blk) : (128 / len + blk);
  endfunction

  // Whether offset t (cycles after the accepting edge) carries an issue, and which one
  function automatic void slot(input int t, output bit v, output int L, output int c);
    v = 0; L = 0; c = 0;
    if (t >= 1) begin
      L = (t - 1) / 133;
      c = (t - 1) % 133;
      v = (L < 7) && (c < 128);
    end
  endfunction

  // Reference state: accepted start edge and mode
  int cyc = 0;
  bit act = 0;
  int s0 = 0;
  int mode = 0;
  int bfu_exp = 0;
  bit chk_on = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      act = 0;
      bfu_exp = 0;
    end else if (bus.i_start && !(act && (cyc - 1 - s0) < 932)) begin
      act = 1;
      s0 = cyc;
      mode = int'(bus.i_intt);
      bfu_exp = mode;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (rst) begin
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_rd_en", int'(bus.o_rd_en), 0);
        chk("rst_wr_en", int'(bus.o_wr_en), 0);
        chk("rst_rd_a", int'(bus.o_rd_addr_a), 0);
        chk("rst_wr_a", int'(bus.o_wr_addr_a), 0);
        chk("rst_zeta", int'(bus.o_zeta_idx), 0);
        chk("rst_bfu_intt", int'(bus.o_bfu_intt), 0);
      end else begin
        int t;
        bit rv, wv;
        int rl, rc, wl, wc, a, b, z;
        t = act ? (cyc - s0) : 100000;
        slot(t, rv, rl, rc);
        slot(t - 5, wv, wl, wc);
        chk("busy", int'(bus.o_busy), int'(act && t <= 931));
        chk("done", int'(bus.o_done), int'(act && t == 932));
        chk("rd_en", int'(bus.o_rd_en), int'(rv));
        chk("wr_en", int'(bus.o_wr_en), int'(wv));
        chk("bfu_intt", int'(bus.o_bfu_intt), bfu_exp);
        if (rv) begin
          pair(rl, rc, mode, a, b, z);
          chk("rd_addr_a", int'(bus.o_rd_addr_a), a);
          chk("rd_addr_b", int'(bus.o_rd_addr_b), b);
          chk("zeta_idx", int'(bus.o_zeta_idx), z);
        end
        if (wv) begin
          pair(wl, wc, mode, a, b, z);
          chk("wr_addr_a", int'(bus.o_wr_addr_a), a);
          chk("wr_addr_b", int'(bus.o_wr_addr_b), b);
        end
        // Hand-derived anchors
        if (act && mode == 0 && t == 1) begin
          chk("lit_fwd_first_a", int'(bus.o_rd_addr_a), 0);
          chk("lit_fwd_first_b", int'(bus.o_rd_addr_b), 128);
          chk("lit_fwd_first_z", int'(bus.o_zeta_idx), 1);
        end
        if (act && mode == 0 && t == 926) begin
          chk("lit_fwd_last_a", int'(bus.o_rd_addr_a), 253);
          chk("lit_fwd_last_b", int'(bus.o_rd_addr_b), 255);
          chk("lit_fwd_last_z", int'(bus.o_zeta_idx), 127);
        end
        if (act && mode == 1 && t == 3) begin
          chk("lit_inv_c2_a", int'(bus.o_rd_addr_a), 4);
          chk("lit_inv_c2_z", int'(bus.o_zeta_idx), 126);
        end
        if (act && t == 134) chk("lit_wr_gap", int'(bus.o_wr_en), 0);
        if (act && t == 932) chk("lit_done_932", int'(bus.o_done), 1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // One transform; optional reset pulse at iteration rst_at (0 = none)
  task automatic run(input bit m, input int rst_at);
    bus.i_start = 1'b1;
    bus.i_intt  = m;
    step();
    bus.i_start = 1'b0;
    for (int k = 1; k <= 945; k++) begin
      step();
      bus.i_intt  = 1'($urandom);
      bus.i_start = (k < 900) && (($urandom % 16 == 0) || k == 49);
      if (rst_at != 0 && k == rst_at) rst = 1'b1;
      if (rst_at != 0 && k == rst_at + 2) begin
        rst = 1'b0;
        bus.i_start = 1'b0;
        break;
      end
    end
    bus.i_start = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    int a, b, z;
    bus.i_start = 1'b0;
    bus.i_intt  = 1'b0;

    pair(0, 0, 0, a, b, z);
    chk("model_fwd_l0c0", a * 100000 + b * 100 + z, 0 * 100000 + 128 * 100 + 1);
    pair(6, 127, 0, a, b, z);
    chk("model_fwd_l6c127", a * 100000 + b * 100 + z, 253 * 100000 + 255 * 100 + 127);
    pair(0, 1, 1, a, b, z);
    chk("model_inv_l0c1", a * 100000 + b * 100 + z, 1 * 100000 + 3 * 100 + 127);
    pair(0, 2, 1, a, b, z);
    chk("model_inv_l0c2", a * 100000 + b * 100 + z, 4 * 100000 + 6 * 100 + 126);
    pair(6, 5, 1, a, b, z);
    chk("model_inv_l6c5", a * 100000 + b * 100 + z, 5 * 100000 + 133 * 100 + 1);

    repeat (2) @(posedge clk);
    chk_on = 1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3 + $urandom_range(0, 4)) step();

    run(1'b0, 0);
    run(1'b1, 0);
    run(1'b0, 300);
    run(1'b0, 0);
    run(1'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
